// File: rtl/eeg_frame_feature_engine.sv
// eeg_frame_feature_engine
//
// Time-multiplexed EEG feature engine. A single shared datapath with
// per-channel state in register arrays accumulates squared samples over a
// 2^WIN_LOG2 window per channel. Each window yields a bandpower value, which is
// clamped and centered against an adaptive IIR baseline. Once every channel
// has finished its window, or once the partial-frame timeout expires, the
// engine walks the channels with a serial MAC over programmable X/Y weights.
// It then presents one feature pair on a valid/ready output.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   s_valid/s_ready      input sample stream handshake (ready only in COLLECT)
//   s_chan, s_data       channel index and signed filtered sample
//   freeze_in            artifact flag: restarts the channel window
//   w_wr_en/addr/x/y     weight register write port (any state)
//   m_valid/m_ready      feature output handshake
//   m_feat_x, m_feat_y   signed weighted features
//   m_partial            frame was closed by the timeout
//   m_frame_id           frame counter, advances on each output handshake
//   drop_count           saturating count of discarded samples
//   busy                 high in BURST or HOLD
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accept samples, update windows/baselines, run frame timeout
// BURST   | serial MAC over channels 0..NUM_CH-1, one channel per cycle
// HOLD    | feature pair presented, waiting for m_ready

module eeg_frame_feature_engine #(
   parameter int NUM_CH     = 8,
   parameter int CH_W       = 3,
   parameter int DATA_W     = 16,
   parameter int WIN_LOG2   = 6,
   parameter int BASE_SHIFT = 6,
   parameter int OUT_SHIFT  = 7,
   parameter int TIMEOUT    = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [CH_W-1:0]          s_chan,
   input  logic signed [DATA_W-1:0] s_data,
   input  logic                     freeze_in,
   input  logic                     w_wr_en,
   input  logic [CH_W-1:0]          w_wr_addr,
   input  logic signed [7:0]        w_wr_x,
   input  logic signed [7:0]        w_wr_y,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic signed [DATA_W-1:0] m_feat_x,
   output logic signed [DATA_W-1:0] m_feat_y,
   output logic                     m_partial,
   output logic [7:0]               m_frame_id,
   output logic [15:0]              drop_count,
   output logic                     busy
);

   localparam int ACC_W  = 2*DATA_W + WIN_LOG2;
   localparam int CNT_W  = WIN_LOG2 + 1;
   localparam int MAC_W  = DATA_W + 9 + CH_W;
   localparam int PROD_W = DATA_W + 8;
   localparam int TMR_W  = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0]        WIN_N    = CNT_W'(2**WIN_LOG2);
   localparam logic [ACC_W-1:0]        PWR_MAX  = ACC_W'(2**(DATA_W-1) - 1);
   localparam logic [TMR_W-1:0]        TMR_LOAD = TMR_W'(TIMEOUT);
   localparam logic [CH_W-1:0]         LAST_IDX = CH_W'(NUM_CH - 1);
   localparam logic signed [MAC_W-1:0] OUT_MAX  = MAC_W'(2**(DATA_W-1) - 1);
   localparam logic signed [MAC_W-1:0] OUT_MIN  = ~OUT_MAX;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      BURST   = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ACC_W-1:0]        acc      [NUM_CH];
   logic [CNT_W-1:0]        cnt      [NUM_CH];
   logic signed [DATA_W-1:0] base    [NUM_CH];
   logic signed [DATA_W-1:0] centered [NUM_CH];
   logic signed [7:0]       wx       [NUM_CH];
   logic signed [7:0]       wy       [NUM_CH];
   logic [NUM_CH-1:0]       done;

   logic [TMR_W-1:0]        tmr;
   logic [CH_W-1:0]         idx;
   logic signed [MAC_W-1:0] mac_x, mac_y;

   // ------------------------------------------------------------------
   // Sample intake
   // ------------------------------------------------------------------
   logic                      accept, chan_ok, sample_ok, freeze_hit, drop_hit;
   logic [CH_W-1:0]           ch_idx;
   logic signed [2*DATA_W-1:0] sq_s;
   logic [ACC_W-1:0]          acc_nxt, pwr_raw;
   logic [CNT_W-1:0]          cnt_nxt;
   logic                      win_full;
   logic [DATA_W-1:0]         power;
   logic signed [DATA_W:0]    diff;
   logic signed [DATA_W-1:0]  cen_new, base_step, base_new;

   always_comb begin
      accept   = s_valid & s_ready;
      chan_ok  = int'(s_chan) < NUM_CH;
      // Out-of-range channels are dropped; park the index so array reads stay in bounds.
      ch_idx   = chan_ok ? s_chan : '0;
      sample_ok  = accept & chan_ok & ~done[ch_idx] & ~freeze_in;
      freeze_hit = accept & chan_ok & ~done[ch_idx] &  freeze_in;
      drop_hit   = accept & (~chan_ok | done[ch_idx] | freeze_in);

      sq_s     = s_data * s_data;
      acc_nxt  = acc[ch_idx] + {{WIN_LOG2{1'b0}}, sq_s};
      cnt_nxt  = cnt[ch_idx] + CNT_W'(1);
      win_full = (cnt_nxt == WIN_N);

      pwr_raw  = acc_nxt >> WIN_LOG2;
      power    = (pwr_raw > PWR_MAX) ? PWR_MAX[DATA_W-1:0] : pwr_raw[DATA_W-1:0];

      diff     = $signed({1'b0, power}) - $signed({base[ch_idx][DATA_W-1], base[ch_idx]});
      if (diff[DATA_W] != diff[DATA_W-1])
         cen_new = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
         cen_new = diff[DATA_W-1:0];
      // Baseline moves a 2^-BASE_SHIFT fraction toward power; it cannot overshoot.
      base_step = DATA_W'(diff >>> BASE_SHIFT);
      base_new  = base[ch_idx] + base_step;
   end

   // ------------------------------------------------------------------
   // Frame close and MAC terms
   // ------------------------------------------------------------------
   logic                      all_done, any_done, timeout_hit, frame_close, last_burst;
   logic signed [DATA_W-1:0]  cen_sel;
   logic signed [PROD_W-1:0]  prod_x, prod_y;
   logic signed [MAC_W-1:0]   prod_x_ext, prod_y_ext, sum_x, sum_y, shx, shy;

   function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [MAC_W-1:0] v);
      if (v > OUT_MAX)
         sat_out = OUT_MAX[DATA_W-1:0];
      else if (v < OUT_MIN)
         sat_out = OUT_MIN[DATA_W-1:0];
      else
         sat_out = v[DATA_W-1:0];
   endfunction

   always_comb begin
      all_done    = &done;
      any_done    = |done;
      timeout_hit = any_done && (tmr == '0);
      frame_close = (state == COLLECT) && (all_done || timeout_hit);
      last_burst  = (state == BURST) && (idx == LAST_IDX);

      // Channels that missed the frame contribute nothing, whatever centered[] holds.
      cen_sel    = done[idx] ? centered[idx] : '0;
      prod_x     = cen_sel * wx[idx];
      prod_y     = cen_sel * wy[idx];
      prod_x_ext = prod_x;
      prod_y_ext = prod_y;
      sum_x      = mac_x + prod_x_ext;
      sum_y      = mac_y + prod_y_ext;
      shx        = sum_x >>> OUT_SHIFT;
      shy        = sum_y >>> OUT_SHIFT;
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst)
         state <= COLLECT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (frame_close) state_nxt = BURST;
         BURST:   if (last_burst)  state_nxt = HOLD;
         HOLD:    if (m_ready)     state_nxt = COLLECT;
         default:                  state_nxt = COLLECT;
      endcase
   end

   always_comb begin
      s_ready = (state == COLLECT) && !rst;
      m_valid = (state == HOLD);
      busy    = (state != COLLECT);
   end

   // ------------------------------------------------------------------
   // Per-channel window / baseline state
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i]      <= '0;
            cnt[i]      <= '0;
            base[i]     <= '0;
            centered[i] <= '0;
         end
         done       <= '0;
         drop_count <= '0;
      end else begin
         if (last_burst)
            done <= '0;

         if (drop_hit && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;

         if (freeze_hit) begin
            acc[ch_idx] <= '0;
            cnt[ch_idx] <= '0;
         end else if (sample_ok) begin
            if (win_full) begin
               acc[ch_idx]      <= '0;
               cnt[ch_idx]      <= '0;
               centered[ch_idx] <= cen_new;
               base[ch_idx]     <= base_new;
               done[ch_idx]     <= 1'b1;
            end else begin
               acc[ch_idx] <= acc_nxt;
               cnt[ch_idx] <= cnt_nxt;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wx[i] <= '0;
            wy[i] <= '0;
         end
      end else if (w_wr_en && int'(w_wr_addr) < NUM_CH) begin
         wx[w_wr_addr] <= w_wr_x;
         wy[w_wr_addr] <= w_wr_y;
      end
   end

   // ------------------------------------------------------------------
   // Timeout down-counter, MAC and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         tmr        <= TMR_LOAD;
         idx        <= '0;
         mac_x      <= '0;
         mac_y      <= '0;
         m_feat_x   <= '0;
         m_feat_y   <= '0;
         m_partial  <= 1'b0;
         m_frame_id <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (any_done && tmr != '0)
                  tmr <= tmr - TMR_W'(1);
               if (frame_close) begin
                  idx   <= '0;
                  mac_x <= '0;
                  mac_y <= '0;
               end
            end
            BURST: begin
               if (last_burst) begin
                  m_feat_x  <= sat_out(shx);
                  m_feat_y  <= sat_out(shy);
                  m_partial <= ~all_done;
                  tmr       <= TMR_LOAD;
               end else begin
                  mac_x <= sum_x;
                  mac_y <= sum_y;
                  idx   <= idx + CH_W'(1);
               end
            end
            HOLD: begin
               if (m_ready)
                  m_frame_id <= m_frame_id + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eeg_frame_feature_engine.sv
module tb_eeg_frame_feature_engine;

   localparam int NUM_CH     = 4;
   localparam int CH_W       = 3;
   localparam int DATA_W     = 16;
   localparam int WIN_LOG2   = 2;
   localparam int BASE_SHIFT = 6;
   localparam int OUT_SHIFT  = 7;
   localparam int TIMEOUT    = 100;
   localparam int WIN_N      = 1 << WIN_LOG2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic                     rst;
   logic                     s_valid, s_ready;
   logic [CH_W-1:0]          s_chan;
   logic signed [DATA_W-1:0] s_data;
   logic                     freeze_in;
   logic                     w_wr_en;
   logic [CH_W-1:0]          w_wr_addr;
   logic signed [7:0]        w_wr_x, w_wr_y;
   logic                     m_valid, m_ready;
   logic signed [DATA_W-1:0] m_feat_x, m_feat_y;
   logic                     m_partial;
   logic [7:0]               m_frame_id;
   logic [15:0]              drop_count;
   logic                     busy;

   eeg_frame_feature_engine #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2),
      .BASE_SHIFT(BASE_SHIFT), .OUT_SHIFT(OUT_SHIFT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
      .freeze_in(freeze_in),
      .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_x(w_wr_x), .w_wr_y(w_wr_y),
      .m_valid(m_valid), .m_ready(m_ready), .m_feat_x(m_feat_x), .m_feat_y(m_feat_y),
      .m_partial(m_partial), .m_frame_id(m_frame_id), .drop_count(drop_count),
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: per-channel sum of squares, sample count, baseline,
   // last centered power and done flag, plus weights and counters.
   longint m_sum  [NUM_CH];
   int     m_cnt  [NUM_CH];
   int     m_base [NUM_CH];
   int     m_cent [NUM_CH];
   bit     m_done [NUM_CH];
   int     m_wx   [NUM_CH];
   int     m_wy   [NUM_CH];
   int     m_drop;
   int     m_fid;
   int     t_last, t_first;

   function automatic int clampi(int v);
      if (v > 32767)  return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int fdiv(int a, int b);
      if (a >= 0) return a / b;
      return -((-a + b - 1) / b);
   endfunction

   task automatic check(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_sum[i] = 0; m_cnt[i] = 0; m_base[i] = 0; m_cent[i] = 0;
         m_done[i] = 0; m_wx[i] = 0; m_wy[i] = 0;
      end
      m_drop = 0;
      m_fid  = 0;
   endtask

   task automatic model_sample(int ch, int d, bit frz);
      longint p;
      int diff;
      if (ch >= NUM_CH || m_done[ch] || frz) begin
         if (m_drop < 65535) m_drop++;
         if (ch < NUM_CH && !m_done[ch] && frz) begin
            m_sum[ch] = 0;
            m_cnt[ch] = 0;
         end
      end else begin
         m_sum[ch] += longint'(d) * longint'(d);
         m_cnt[ch]++;
         if (m_cnt[ch] == WIN_N) begin
            p = m_sum[ch] / WIN_N;
            if (p > 32767) p = 32767;
            diff = int'(p) - m_base[ch];
            m_cent[ch] = clampi(diff);
            m_base[ch] += fdiv(diff, 1 << BASE_SHIFT);
            m_sum[ch] = 0;
            m_cnt[ch] = 0;
            m_done[ch] = 1;
         end
      end
   endtask

   task automatic w_write(int a, int x, int y);
      w_wr_en = 1'b1; w_wr_addr = a[CH_W-1:0]; w_wr_x = x[7:0]; w_wr_y = y[7:0];
      @(posedge clk); #1;
      w_wr_en = 1'b0;
      if (a < NUM_CH) begin
         m_wx[a] = x;
         m_wy[a] = y;
      end
   endtask

   task automatic send(int ch, int d, bit frz);
      int i;
      for (i = 0; i < 200 && s_ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      if (s_ready !== 1'b1) check("send_ready_timeout", int'(s_ready), 1);
      s_valid = 1'b1; s_chan = ch[CH_W-1:0]; s_data = d[DATA_W-1:0]; freeze_in = frz;
      @(posedge clk); #1;
      s_valid = 1'b0; freeze_in = 1'b0;
      t_last = cyc;
      model_sample(ch, d, frz);
   endtask

   task automatic expect_frame(string tag, int t_ref, int lat, int hold);
      int fx, fy, ex, ey, tv;
      bit part;
      fx = 0; fy = 0; part = 0;
      for (int i = 0; i < 400 && m_valid !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      check({tag, "_valid"}, int'(m_valid), 1);
      tv = cyc;
      check({tag, "_latency"}, tv - t_ref, lat);
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_done[c]) begin
            fx += m_cent[c] * m_wx[c];
            fy += m_cent[c] * m_wy[c];
         end else begin
            part = 1;
         end
      end
      ex = clampi(fdiv(fx, 1 << OUT_SHIFT));
      ey = clampi(fdiv(fy, 1 << OUT_SHIFT));
      check({tag, "_x"}, int'($signed(m_feat_x)), ex);
      check({tag, "_y"}, int'($signed(m_feat_y)), ey);
      check({tag, "_partial"}, int'(m_partial), int'(part));
      check({tag, "_frame_id"}, int'(m_frame_id), m_fid);
      check({tag, "_busy"}, int'(busy), 1);
      check({tag, "_s_ready"}, int'(s_ready), 0);
      if (hold > 0) begin
         // Offer an out-of-range sample while held; it must not be accepted.
         s_valid = 1'b1; s_chan = 3'd5; s_data = 16'sd7;
         for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, int'(m_valid), 1);
            check({tag, "_hold_ready"}, int'(s_ready), 0);
            check({tag, "_hold_x"}, int'($signed(m_feat_x)), ex);
            check({tag, "_hold_y"}, int'($signed(m_feat_y)), ey);
         end
         s_valid = 1'b0;
         m_ready = 1'b1;
      end
      @(posedge clk); #1;
      m_fid = (m_fid + 1) % 256;
      for (int c = 0; c < NUM_CH; c++) m_done[c] = 0;
      check({tag, "_after_valid"}, int'(m_valid), 0);
      check({tag, "_after_id"}, int'(m_frame_id), m_fid);
      check({tag, "_after_ready"}, int'(s_ready), 1);
   endtask

   task automatic rand_frame();
      int c, d;
      bit all;
      all = 0;
      while (!all) begin
         c = $urandom_range(0, NUM_CH - 1);
         d = int'($urandom_range(0, 65535)) - 32768;
         if (!m_done[c]) send(c, d, 0);
         all = 1;
         for (int i = 0; i < NUM_CH; i++) if (!m_done[i]) all = 0;
      end
   endtask

   task automatic check_idle_outputs(string tag, int ready_exp);
      check({tag, "_s_ready"}, int'(s_ready), ready_exp);
      check({tag, "_m_valid"}, int'(m_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_x"}, int'($signed(m_feat_x)), 0);
      check({tag, "_y"}, int'($signed(m_feat_y)), 0);
      check({tag, "_partial"}, int'(m_partial), 0);
      check({tag, "_frame_id"}, int'(m_frame_id), 0);
      check({tag, "_drop"}, int'(drop_count), 0);
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_chan = '0; s_data = '0; freeze_in = 1'b0;
      w_wr_en = 1'b0; w_wr_addr = '0; w_wr_x = '0; w_wr_y = '0; m_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("in_reset", 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_idle_outputs("after_reset", 1);

      // Frame A/B: identical full frames, baseline adapts between them.
      w_write(0, 64, 0);
      w_write(1, 0, -64);
      w_write(5, 99, 99);
      for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < WIN_N; k++) send(c, 100, 0);
      expect_frame("frameA", t_last, NUM_CH + 1, 0);
      check("frameA_const_x", int'($signed(m_feat_x)), 5000);
      check("frameA_const_y", int'($signed(m_feat_y)), -5000);

      for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < WIN_N; k++) send(c, 100, 0);
      expect_frame("frameB", t_last, NUM_CH + 1, 0);
      check("frameB_const_x", int'($signed(m_feat_x)), 4922);
      check("frameB_const_y", int'($signed(m_feat_y)), -4922);

      // Partial frame: channel 3 gets only half a window; timeout closes the frame.
      w_write(3, 10, 10);
      for (int k = 0; k < WIN_N; k++) send(0, 100, 0);
      t_first = t_last;
      for (int c = 1; c < 3; c++) for (int k = 0; k < WIN_N; k++) send(c, 100, 0);
      send(3, 1000, 0);
      send(3, 1000, 0);
      expect_frame("timeout", t_first, TIMEOUT + NUM_CH + 1, 0);
      check("timeout_const_partial", int'(m_partial), 1);

      // Clamp frame: full-scale negative samples on ch0; ch3 completes its retained window.
      send(3, 1000, 0);
      send(3, 1000, 0);
      for (int k = 0; k < WIN_N; k++) send(0, -32768, 0);
      for (int c = 1; c < 3; c++)
         for (int k = 0; k < WIN_N; k++) send(c, int'($urandom_range(0, 4000)) - 2000, 0);
      expect_frame("clamp", t_last, NUM_CH + 1, 0);

      // Drops: freeze restart, overrun, out-of-range channel.
      send(0, 200, 0);
      send(0, 200, 1);
      for (int k = 0; k < WIN_N; k++) send(1, 300, 0);
      send(1, 300, 0);
      send(5, 123, 0);
      check("drop_count_3", int'(drop_count), 3);
      for (int c = 2; c < NUM_CH; c++) for (int k = 0; k < WIN_N; k++) send(c, 400, 0);
      for (int k = 0; k < WIN_N - 1; k++) send(0, 500, 0);
      repeat (3) @(posedge clk);
      #1;
      check("ch0_not_done_busy", int'(busy), 0);
      check("ch0_not_done_valid", int'(m_valid), 0);
      send(0, 500, 0);
      expect_frame("drops", t_last, NUM_CH + 1, 0);

      // Randomized frames with random weights; the middle one is held 20 cycles.
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < NUM_CH; c++)
            w_write(c, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
         if (r == 1) m_ready = 1'b0;
         rand_frame();
         expect_frame("random", t_last, NUM_CH + 1, (r == 1) ? 20 : 0);
      end
      check("drop_count_final", int'(drop_count), m_drop);

      // Reset in the middle of a burst.
      rand_frame();
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("burst_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("midburst_rst", 0);
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_idle_outputs("post_rst", 1);

      w_write(0, 64, 0);
      w_write(1, 0, -64);
      for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < WIN_N; k++) send(c, 100, 0);
      expect_frame("restart", t_last, NUM_CH + 1, 0);
      check("restart_const_x", int'($signed(m_feat_x)), 5000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
